// File: rtl/aurora_pkg.sv
// Shared constants and types for the Aurora stream bridge.
package aurora_pkg;

    localparam logic [15:0] NFC_XOFF = 16'h00FF;
    localparam logic [15:0] NFC_XON  = 16'h0000;

    typedef enum logic [1:0] {
        NFC_ST_XON,
        NFC_ST_SEND_XOFF,
        NFC_ST_XOFF,
        NFC_ST_SEND_XON
    } nfc_state_t;

endpackage

// File: rtl/aurora_sync_fifo.sv
// Single-clock first-word-fall-through FIFO with occupancy output and
// synchronous flush. A write while full is accepted only if a read happens
// in the same cycle.
module aurora_sync_fifo #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 64
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       flush_i,
    input  logic                       wr_en_i,
    input  logic [WIDTH-1:0]           wr_data_i,
    input  logic                       rd_en_i,
    output logic [WIDTH-1:0]           rd_data_o,
    output logic                       full_o,
    output logic                       empty_o,
    output logic [$clog2(DEPTH):0]     level_o
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [AW:0]      level_q, level_d;
    logic             do_wr, do_rd;

    assign full_o    = (level_q == FULL_LVL);
    assign empty_o   = (level_q == '0);
    assign level_o   = level_q;
    assign rd_data_o = mem_q[rd_ptr_q];

    assign do_rd = rd_en_i && !empty_o;
    assign do_wr = wr_en_i && (!full_o || do_rd);

    // Occupancy next value: simultaneous write and read cancel out.
    always_comb begin
        level_d = level_q;
        case ({do_wr, do_rd})
            2'b10:   level_d = level_q + (AW+1)'(1);
            2'b01:   level_d = level_q - (AW+1)'(1);
            default: level_d = level_q;
        endcase
    end

    // Storage array; contents need no reset since level gates visibility.
    always_ff @(posedge clk_i) begin
        if (do_wr && !flush_i) begin
            mem_q[wr_ptr_q] <= wr_data_i;
        end
    end

    // Pointer and level registers; flush returns to the empty state.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else if (flush_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            if (do_wr) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (do_rd) rd_ptr_q <= rd_ptr_q + AW'(1);
            level_q <= level_d;
        end
    end

endmodule

// File: rtl/aurora_stream_bridge.sv
// Bridge between user AXI-Stream ports and an Aurora core: buffered TX and
// RX paths plus native flow control (XON/XOFF) driven by RX occupancy.
//
// NFC FSM
//   state          | meaning
//   NFC_ST_XON     | link partner free to send; watching for RX high water
//   NFC_ST_SEND_XOFF | XOFF request offered to core, held until accepted
//   NFC_ST_XOFF    | partner paused; watching for RX low water
//   NFC_ST_SEND_XON | XON request offered to core, held until accepted
module aurora_stream_bridge
    import aurora_pkg::*;
#(
    parameter int DATA_W   = 64,
    parameter int TX_DEPTH = 64,
    parameter int RX_DEPTH = 128,
    parameter int XOFF_LVL = RX_DEPTH - 32,
    parameter int XON_LVL  = RX_DEPTH / 4
) (
    input  logic                        aurora_userclk,
    input  logic                        aurora_rst_n,
    input  logic                        aurora_channel_up,
    input  logic [DATA_W-1:0]           s_axis_tdata,
    input  logic                        s_axis_tvalid,
    output logic                        s_axis_tready,
    output logic [DATA_W-1:0]           core_tx_tdata,
    output logic                        core_tx_tvalid,
    input  logic                        core_tx_tready,
    input  logic [DATA_W-1:0]           core_rx_tdata,
    input  logic                        core_rx_tvalid,
    output logic [DATA_W-1:0]           m_axis_tdata,
    output logic                        m_axis_tvalid,
    input  logic                        m_axis_tready,
    output logic [15:0]                 core_nfc_tdata,
    output logic                        core_nfc_tvalid,
    input  logic                        core_nfc_tready,
    output logic [$clog2(TX_DEPTH):0]   tx_level,
    output logic [$clog2(RX_DEPTH):0]   rx_level,
    output logic [15:0]                 rx_ovf_cnt
);

    localparam int RX_LW = $clog2(RX_DEPTH) + 1;
    localparam logic [RX_LW-1:0] XOFF_L = RX_LW'(XOFF_LVL);
    localparam logic [RX_LW-1:0] XON_L  = RX_LW'(XON_LVL);

    logic       flush;
    logic       tx_full, tx_empty, tx_push, tx_pop;
    logic       rx_full, rx_empty, rx_wr, rx_pop, rx_drop;
    logic [15:0] ovf_q;
    nfc_state_t state_q, state_d;

    assign flush = !aurora_channel_up;

    // Ready is also held low while reset is asserted so the user side sees
    // an idle block immediately, not only after the first clock.
    assign s_axis_tready  = !tx_full && aurora_channel_up && aurora_rst_n;
    assign tx_push        = s_axis_tvalid && s_axis_tready;
    assign core_tx_tvalid = !tx_empty && aurora_channel_up;
    assign tx_pop         = core_tx_tvalid && core_tx_tready;

    assign rx_wr         = core_rx_tvalid && aurora_channel_up;
    assign m_axis_tvalid = !rx_empty;
    assign rx_pop        = m_axis_tvalid && m_axis_tready;
    assign rx_drop       = rx_wr && rx_full && !rx_pop;
    assign rx_ovf_cnt    = ovf_q;

    aurora_sync_fifo #(.WIDTH(DATA_W), .DEPTH(TX_DEPTH)) u_tx_fifo (
        .clk_i     (aurora_userclk),
        .rst_ni    (aurora_rst_n),
        .flush_i   (flush),
        .wr_en_i   (tx_push),
        .wr_data_i (s_axis_tdata),
        .rd_en_i   (tx_pop),
        .rd_data_o (core_tx_tdata),
        .full_o    (tx_full),
        .empty_o   (tx_empty),
        .level_o   (tx_level)
    );

    aurora_sync_fifo #(.WIDTH(DATA_W), .DEPTH(RX_DEPTH)) u_rx_fifo (
        .clk_i     (aurora_userclk),
        .rst_ni    (aurora_rst_n),
        .flush_i   (flush),
        .wr_en_i   (rx_wr),
        .wr_data_i (core_rx_tdata),
        .rd_en_i   (rx_pop),
        .rd_data_o (m_axis_tdata),
        .full_o    (rx_full),
        .empty_o   (rx_empty),
        .level_o   (rx_level)
    );

    // Dropped-word counter, saturating; survives channel drops.
    always_ff @(posedge aurora_userclk or negedge aurora_rst_n) begin
        if (!aurora_rst_n) begin
            ovf_q <= '0;
        end else if (rx_drop && (ovf_q != 16'hFFFF)) begin
            ovf_q <= ovf_q + 16'd1;
        end
    end

    // NFC state register.
    always_ff @(posedge aurora_userclk or negedge aurora_rst_n) begin
        if (!aurora_rst_n) begin
            state_q <= NFC_ST_XON;
        end else begin
            state_q <= state_d;
        end
    end

    // NFC next state and request outputs; a channel drop abandons any request.
    always_comb begin
        state_d         = state_q;
        core_nfc_tvalid = 1'b0;
        core_nfc_tdata  = 16'h0000;
        case (state_q)
            NFC_ST_XON: begin
                if (rx_level >= XOFF_L) state_d = NFC_ST_SEND_XOFF;
            end
            NFC_ST_SEND_XOFF: begin
                core_nfc_tvalid = 1'b1;
                core_nfc_tdata  = NFC_XOFF;
                if (core_nfc_tready) state_d = NFC_ST_XOFF;
            end
            NFC_ST_XOFF: begin
                if (rx_level <= XON_L) state_d = NFC_ST_SEND_XON;
            end
            NFC_ST_SEND_XON: begin
                core_nfc_tvalid = 1'b1;
                core_nfc_tdata  = NFC_XON;
                if (core_nfc_tready) state_d = NFC_ST_XON;
            end
            default: state_d = NFC_ST_XON;
        endcase
        if (!aurora_channel_up) state_d = NFC_ST_XON;
    end

endmodule

// File: tb/tb_aurora_stream_bridge.sv
// Randomized bench for aurora_stream_bridge against a queue-based model.
module tb_aurora_stream_bridge;

    localparam int DW   = 16;
    localparam int TXD  = 16;
    localparam int RXD  = 16;
    localparam int XOFF = 10;
    localparam int XON  = 4;

    logic                    clk = 1'b0;
    logic                    rst_n;
    logic                    ch;
    logic [DW-1:0]           s_tdata;
    logic                    s_tvalid;
    logic                    s_tready;
    logic [DW-1:0]           tx_tdata;
    logic                    tx_tvalid;
    logic                    tx_tready;
    logic [DW-1:0]           rx_tdata;
    logic                    rx_tvalid;
    logic [DW-1:0]           m_tdata;
    logic                    m_tvalid;
    logic                    m_tready;
    logic [15:0]             nfc_tdata;
    logic                    nfc_tvalid;
    logic                    nfc_tready;
    logic [$clog2(TXD):0]    tx_level;
    logic [$clog2(RXD):0]    rx_level;
    logic [15:0]             ovf_cnt;

    aurora_stream_bridge #(
        .DATA_W(DW), .TX_DEPTH(TXD), .RX_DEPTH(RXD), .XOFF_LVL(XOFF), .XON_LVL(XON)
    ) dut (
        .aurora_userclk    (clk),
        .aurora_rst_n      (rst_n),
        .aurora_channel_up (ch),
        .s_axis_tdata      (s_tdata),
        .s_axis_tvalid     (s_tvalid),
        .s_axis_tready     (s_tready),
        .core_tx_tdata     (tx_tdata),
        .core_tx_tvalid    (tx_tvalid),
        .core_tx_tready    (tx_tready),
        .core_rx_tdata     (rx_tdata),
        .core_rx_tvalid    (rx_tvalid),
        .m_axis_tdata      (m_tdata),
        .m_axis_tvalid     (m_tvalid),
        .m_axis_tready     (m_tready),
        .core_nfc_tdata    (nfc_tdata),
        .core_nfc_tvalid   (nfc_tvalid),
        .core_nfc_tready   (nfc_tready),
        .tx_level          (tx_level),
        .rx_level          (rx_level),
        .rx_ovf_cnt        (ovf_cnt)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Reference model: plain queues plus a pending-request record for NFC.
    logic [DW-1:0] txq[$];
    logic [DW-1:0] rxq[$];
    int            m_ovf;
    bit            m_pend;
    logic [15:0]   m_pend_code;
    bit            m_paused;
    int            hs_xoff, hs_xon;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h t=%0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_clear(input bit keep_ovf);
        txq.delete();
        rxq.delete();
        m_pend   = 1'b0;
        m_paused = 1'b0;
        if (!keep_ovf) m_ovf = 0;
    endtask

    task automatic idle_inputs();
        s_tvalid   = 1'b0;
        s_tdata    = '0;
        tx_tready  = 1'b0;
        rx_tvalid  = 1'b0;
        rx_tdata   = '0;
        m_tready   = 1'b0;
        nfc_tready = 1'b0;
    endtask

    // One clock cycle: inputs already set at the falling edge; compare, then
    // advance the model with this cycle's handshakes.
    task automatic tick();
        bit   exp_srdy;
        bit   rx_pop;
        int   lvl;
        #1;
        exp_srdy = ch && (txq.size() < TXD);
        chk("s_tready", 32'(s_tready), 32'(exp_srdy));
        chk("tx_tvalid", 32'(tx_tvalid), 32'(ch && (txq.size() > 0)));
        if (ch && txq.size() > 0) chk("tx_tdata", 32'(tx_tdata), 32'(txq[0]));
        chk("tx_level", 32'(tx_level), txq.size());
        chk("m_tvalid", 32'(m_tvalid), 32'(rxq.size() > 0));
        if (rxq.size() > 0) chk("m_tdata", 32'(m_tdata), 32'(rxq[0]));
        chk("rx_level", 32'(rx_level), rxq.size());
        chk("ovf_cnt", 32'(ovf_cnt), m_ovf);
        chk("nfc_tvalid", 32'(nfc_tvalid), 32'(m_pend));
        chk("nfc_tdata", 32'(nfc_tdata), m_pend ? 32'(m_pend_code) : 32'd0);
        if (nfc_tvalid && nfc_tready) begin
            if (nfc_tdata == 16'h00FF) hs_xoff++;
            else hs_xon++;
        end

        if (!ch) begin
            model_clear(1'b1);
        end else begin
            lvl = rxq.size();
            if (txq.size() > 0 && tx_tready) void'(txq.pop_front());
            if (s_tvalid && exp_srdy) txq.push_back(s_tdata);
            rx_pop = (rxq.size() > 0) && m_tready;
            if (rx_tvalid) begin
                if (rxq.size() < RXD || rx_pop) begin
                    if (rx_pop) void'(rxq.pop_front());
                    rxq.push_back(rx_tdata);
                end else begin
                    if (m_ovf < 65535) m_ovf++;
                end
            end else if (rx_pop) begin
                void'(rxq.pop_front());
            end
            if (m_pend) begin
                if (nfc_tready) begin
                    m_paused = (m_pend_code == 16'h00FF);
                    m_pend   = 1'b0;
                end
            end else if (!m_paused && lvl >= XOFF) begin
                m_pend      = 1'b1;
                m_pend_code = 16'h00FF;
            end else if (m_paused && lvl <= XON) begin
                m_pend      = 1'b1;
                m_pend_code = 16'h0000;
            end
        end
        @(negedge clk);
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_srdy"}, 32'(s_tready), 0);
        chk({tag, "_txv"}, 32'(tx_tvalid), 0);
        chk({tag, "_mv"}, 32'(m_tvalid), 0);
        chk({tag, "_nfcv"}, 32'(nfc_tvalid), 0);
        chk({tag, "_nfcd"}, 32'(nfc_tdata), 0);
        chk({tag, "_txl"}, 32'(tx_level), 0);
        chk({tag, "_rxl"}, 32'(rx_level), 0);
        chk({tag, "_ovf"}, 32'(ovf_cnt), 0);
    endtask

    initial begin
        int acc;
        rst_n = 1'b0;
        ch    = 1'b1;
        idle_inputs();
        model_clear(1'b0);
        hs_xoff = 0;
        hs_xon  = 0;

        #3;
        check_all_zero("reset");
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Five words through TX with the core always ready.
        tx_tready = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            s_tvalid = 1'b1;
            s_tdata  = DW'(i);
            tick();
            chk("t035_next", 32'(tx_tdata), i);
        end
        s_tvalid = 1'b0;
        for (int i = 0; i < 4; i++) tick();

        // TX fill past capacity with the core stalled.
        tx_tready = 1'b0;
        acc = 0;
        for (int i = 0; i < TXD + 2; i++) begin
            s_tvalid = 1'b1;
            s_tdata  = DW'(16'h0100 + acc);
            if (txq.size() < TXD) acc++;
            tick();
        end
        chk("t036_level", 32'(tx_level), TXD);
        chk("t036_srdy", 32'(s_tready), 0);
        s_tvalid  = 1'b0;
        tx_tready = 1'b1;
        for (int i = 0; i < 3 * TXD && txq.size() > 0; i++) tick();
        chk("t036_empty", 32'(tx_level), 0);

        // RX overflow by three words with the user side stalled.
        tx_tready  = 1'b0;
        m_tready   = 1'b0;
        nfc_tready = 1'b1;
        for (int i = 0; i < RXD + 3; i++) begin
            rx_tvalid = 1'b1;
            rx_tdata  = DW'($urandom);
            tick();
        end
        rx_tvalid = 1'b0;
        chk("t037_ovf", 32'(ovf_cnt), 3);
        chk("t037_level", 32'(rx_level), RXD);
        m_tready = 1'b1;
        for (int i = 0; i < 3 * RXD && rxq.size() > 0; i++) tick();
        for (int i = 0; i < 4; i++) tick();

        // One XOFF held under backpressure, then one XON after draining.
        hs_xoff    = 0;
        hs_xon     = 0;
        m_tready   = 1'b0;
        nfc_tready = 1'b0;
        for (int i = 0; i < XOFF; i++) begin
            rx_tvalid = 1'b1;
            rx_tdata  = DW'($urandom);
            tick();
        end
        rx_tvalid = 1'b0;
        tick();
        for (int i = 0; i < 3; i++) begin
            chk("t038_hold_v", 32'(nfc_tvalid), 1);
            chk("t038_hold_d", 32'(nfc_tdata), 32'h00FF);
            tick();
        end
        nfc_tready = 1'b1;
        tick();
        nfc_tready = 1'b0;
        m_tready   = 1'b1;
        for (int i = 0; i < 3 * RXD && rxq.size() > 0; i++) tick();
        for (int i = 0; i < 2; i++) tick();
        chk("t038_xon_v", 32'(nfc_tvalid), 1);
        nfc_tready = 1'b1;
        for (int i = 0; i < 3; i++) tick();
        chk("t038_n_xoff", hs_xoff, 1);
        chk("t038_n_xon", hs_xon, 1);

        // Channel drop with both FIFOs loaded and XOFF pending.
        tx_tready  = 1'b0;
        m_tready   = 1'b0;
        nfc_tready = 1'b0;
        for (int i = 0; i < 10; i++) begin
            s_tvalid  = 1'b1;
            s_tdata   = DW'($urandom);
            rx_tvalid = 1'b1;
            rx_tdata  = DW'($urandom);
            tick();
        end
        s_tvalid  = 1'b0;
        rx_tvalid = 1'b0;
        tick();
        chk("t039_txl", 32'(tx_level), 10);
        chk("t039_rxl", 32'(rx_level), 10);
        chk("t039_pend", 32'(nfc_tvalid), 1);
        ch = 1'b0;
        tick();
        ch = 1'b1;
        chk("t039_txl0", 32'(tx_level), 0);
        chk("t039_rxl0", 32'(rx_level), 0);
        chk("t039_nfcv", 32'(nfc_tvalid), 0);
        chk("t039_txv", 32'(tx_tvalid), 0);
        chk("t039_mv", 32'(m_tvalid), 0);
        nfc_tready = 1'b1;
        for (int i = 0; i < 4; i++) tick();

        // Randomized traffic with occasional channel drops.
        for (int i = 0; i < 600; i++) begin
            ch         = ($urandom_range(0, 40) != 0);
            s_tvalid   = $urandom_range(0, 1);
            s_tdata    = DW'($urandom);
            tx_tready  = ($urandom_range(0, 3) != 0);
            rx_tvalid  = ($urandom_range(0, 4) < 3);
            rx_tdata   = DW'($urandom);
            m_tready   = $urandom_range(0, 1);
            nfc_tready = $urandom_range(0, 1);
            tick();
        end
        ch = 1'b1;
        idle_inputs();
        tick();

        // Asynchronous reset in the middle of traffic.
        for (int i = 0; i < 3; i++) begin
            s_tvalid  = 1'b1;
            s_tdata   = DW'(16'h0A00 + i);
            rx_tvalid = 1'b1;
            rx_tdata  = DW'(16'h0B00 + i);
            tick();
        end
        idle_inputs();
        #3;
        rst_n = 1'b0;
        #1;
        check_all_zero("t040_async");
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        model_clear(1'b0);
        tx_tready = 1'b1;
        m_tready  = 1'b0;
        s_tvalid  = 1'b1;
        s_tdata   = DW'(16'hABCD);
        rx_tvalid = 1'b1;
        rx_tdata  = DW'(16'h1234);
        tick();
        idle_inputs();
        tx_tready = 1'b1;
        chk("t040_txv", 32'(tx_tvalid), 1);
        chk("t040_txd", 32'(tx_tdata), 32'hABCD);
        chk("t040_mv", 32'(m_tvalid), 1);
        chk("t040_md", 32'(m_tdata), 32'h1234);
        m_tready = 1'b1;
        for (int i = 0; i < 3; i++) tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout got=running want=finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/aurora_stream_bridge.md
AURORA_STREAM_BRIDGE -- requirements
Module: aurora_stream_bridge

Interface
REQ-001 Parameter DATA_W, default 64: stream data width on both user and core sides.
REQ-002 Parameter TX_DEPTH, default 64: TX FIFO depth in words; power of two, at least 4.
REQ-003 Parameter RX_DEPTH, default 128: RX FIFO depth in words; power of two, at least 8.
REQ-004 Parameter XOFF_LVL, default RX_DEPTH-32: RX fill level at or above which XOFF is requested.
REQ-005 Parameter XON_LVL, default RX_DEPTH/4: RX fill level at or below which XON is requested; must be less than XOFF_LVL.
REQ-006 One clock and one reset; the reset is asynchronous and active-low.
REQ-007 aurora_userclk  in  1  sole clock (core user_clk).
REQ-008 aurora_rst_n  in  1  asynchronous active-low reset.
REQ-009 aurora_channel_up  in  1  core link status.
REQ-010 s_axis_tdata/tvalid  in  DATA_W/1  user TX stream; s_axis_tready  out  1.
REQ-011 core_tx_tdata/tvalid  out  DATA_W/1  to core TX; core_tx_tready  in  1.
REQ-012 core_rx_tdata/tvalid  in  DATA_W/1  from core RX; this interface has no backpressure.
REQ-013 m_axis_tdata/tvalid  out  DATA_W/1  user RX stream; m_axis_tready  in  1.
REQ-014 core_nfc_tdata/tvalid  out  16/1  NFC request to core; core_nfc_tready  in  1.
REQ-015 tx_level, rx_level  out  $clog2(depth)+1  FIFO occupancy; rx_ovf_cnt  out  16  count of dropped RX words.

Function
REQ-016 TX path: s_axis_tready = !tx_full && channel_up; a word is written on tvalid&&tready.
REQ-017 TX path: core_tx_tvalid = !tx_empty && channel_up; a word is popped on core_tx_tvalid&&core_tx_tready.
REQ-018 TX FIFO is first-word-fall-through with no bubbles: a word accepted in cycle N is presented on core_tx_tdata in cycle N+1 when the FIFO was empty.
REQ-019 A simultaneous TX push and pop leaves tx_level unchanged.
REQ-020 RX path: a core_rx word is written when core_rx_tvalid && channel_up.
REQ-021 RX full: the incoming word is written if m_axis pops in the same cycle; otherwise it is dropped and rx_ovf_cnt increments, saturating at 0xFFFF.
REQ-022 RX output: m_axis_tvalid = !rx_empty; 1-cycle latency from core_rx_tvalid to m_axis_tvalid; tdata held stable while tvalid && !tready.
REQ-023 NFC FSM states: XON, SEND_XOFF, XOFF, SEND_XON.
REQ-024 XON -> SEND_XOFF when rx_level >= XOFF_LVL and channel_up.
REQ-025 SEND_XOFF drives core_nfc_tvalid=1 with tdata=NFC_XOFF, held stable until core_nfc_tready, then -> XOFF.
REQ-026 XOFF -> SEND_XON when rx_level <= XON_LVL.
REQ-027 SEND_XON drives core_nfc_tvalid=1 with tdata=NFC_XON, held stable until core_nfc_tready, then -> XON.
REQ-028 In XON and XOFF, core_nfc_tvalid=0 and core_nfc_tdata=0.
REQ-029 channel_up low in any cycle: next cycle both FIFOs are flushed (levels 0), FSM -> XON, and all tvalid outputs are 0; rx_ovf_cnt is retained.
REQ-030 A pending NFC request is abandoned on channel drop; it is not replayed when the channel returns.

Reset
REQ-031 Asserting aurora_rst_n immediately clears both FIFO pointers and levels, rx_ovf_cnt, and all valid/ready outputs, sets core_nfc_tdata=0, and sets FSM=XON.
REQ-032 Reset mid-transfer discards all buffered data; the first cycle after deassertion behaves as an empty, idle block.

Structure
REQ-033 Package aurora_pkg holds NFC_XOFF (16'h00FF), NFC_XON (16'h0000) and the nfc_state_t enum.
REQ-034 Sub-module aurora_sync_fifo (parameters WIDTH, DEPTH; FWFT; level output; sync flush input) is instantiated once for TX and once for RX.

Verification
REQ-035 channel_up=1; push 5 words 1..5 with core_tx_tready=1 -> core_tx outputs 1..5 in order, first one cycle after acceptance, no gaps.
REQ-036 core_tx_tready=0; push TX_DEPTH+2 words -> s_axis_tready falls after word TX_DEPTH, tx_level=TX_DEPTH, no data lost.
REQ-037 m_axis_tready=0; RX_DEPTH+3 core_rx words -> rx_ovf_cnt=3 and the first RX_DEPTH words are intact.
REQ-038 RX filled to XOFF_LVL -> one NFC 0x00FF, held 3 cycles under core_nfc_tready=0; drain to XON_LVL -> one NFC 0x0000.
REQ-039 channel_up drops with 10 words buffered each way and SEND_XOFF pending -> next cycle levels 0, nfc_tvalid=0, FSM XON.
REQ-040 aurora_rst_n asserted mid-stream -> all outputs 0 asynchronously; after release, a fresh word passes with 1-cycle latency.
